bram_tdp_banked: RTL and testbench

Parametrised true-dual-port block RAM for CNN feature-map and weight buffers, built from NBANK interleaved banks selected by the low address bits. Adds a selectable write mode, read latency of 1 or 2 with aligned valid strobes, a same-address collision flag, and a hardware clear sequencer that zeroes the whole array after reset or on request. It sits between the layer engines (conv, pool, dense) and their operand/result storage, replacing plain single-bank TDP instances.

---
 rtl/bram_pkg.sv | 16 +
 rtl/bram_tdp_bank.sv | 44 ++++
 rtl/bram_tdp_banked.sv | 163 ++++++++++++++++
 tb/tb_bram_tdp_banked.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared types and limits for the banked true-dual-port RAM
package bram_pkg;

    typedef enum logic {
        WR_READ_FIRST  = 1'b0,
        WR_WRITE_FIRST = 1'b1
    } wr_mode_e;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_e;

    localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/bram_tdp_bank.sv
// rtl/bram_tdp_bank.sv - one true-dual-port bank, 1-cycle registered read
module bram_tdp_bank
    import bram_pkg::*;
#(
    parameter int DW      = 16,
    parameter int WORDS   = 256,
    parameter int WR_MODE = 0,
    parameter int RW      = $clog2(WORDS)
) (
    input  logic                 clk,
    input  logic                 a_en,
    input  logic                 a_we,
    input  logic [RW-1:0]        a_addr,
    input  logic signed [DW-1:0] a_din,
    output logic signed [DW-1:0] a_dout,
    input  logic                 b_en,
    input  logic                 b_we,
    input  logic [RW-1:0]        b_addr,
    input  logic signed [DW-1:0] b_din,
    output logic signed [DW-1:0] b_dout
);

    localparam bit WRITE_FIRST = (WR_MODE == int'(WR_WRITE_FIRST));

    (* ram_style = "block" *) logic signed [DW-1:0] mem [WORDS];

    // Port A's write is issued last so it wins a same-address double write.
    // Reads sample the pre-edge contents, so a cross-port reader sees old data.
    always_ff @(posedge clk) begin
        if (b_en && b_we) begin
            mem[b_addr] <= b_din;
        end
        if (a_en && a_we) begin
            mem[a_addr] <= a_din;
        end
        if (a_en) begin
            a_dout <= (a_we && WRITE_FIRST) ? a_din : mem[a_addr];
        end
        if (b_en) begin
            b_dout <= (b_we && WRITE_FIRST) ? b_din : mem[b_addr];
        end
    end

endmodule

// File: rtl/bram_tdp_banked.sv
// rtl/bram_tdp_banked.sv - banked true-dual-port RAM with clear sweep and collision flag
module bram_tdp_banked
    import bram_pkg::*;
#(
    parameter int DW             = 16,
    parameter int DEPTH          = 1024,
    parameter int NBANK          = 4,
    parameter int RD_LAT         = 1,
    parameter int WR_MODE        = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter int AW             = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_req,
    output logic                 busy,
    input  logic                 a_en,
    input  logic                 a_we,
    input  logic [AW-1:0]        a_addr,
    input  logic signed [DW-1:0] a_din,
    output logic signed [DW-1:0] a_dout,
    output logic                 a_dvalid,
    input  logic                 b_en,
    input  logic                 b_we,
    input  logic [AW-1:0]        b_addr,
    input  logic signed [DW-1:0] b_din,
    output logic signed [DW-1:0] b_dout,
    output logic                 b_dvalid,
    output logic                 coll
);

    localparam int BW   = (NBANK > 1) ? $clog2(NBANK) : 0;
    localparam int BSW  = (BW > 0) ? BW : 1;
    localparam int ROWS = DEPTH / NBANK;
    localparam int RW   = AW - BW;
    localparam int LAT  = (RD_LAT >= RD_LAT_MAX) ? RD_LAT_MAX : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    clr_state_e    state, state_nxt;
    logic [RW-1:0] clr_row, clr_row_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLR_SWEEP : CLR_IDLE;
            clr_row <= '0;
        end else begin
            state   <= state_nxt;
            clr_row <= clr_row_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_row_nxt = clr_row;
        case (state)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_nxt = CLR_SWEEP;
                end
            end
            CLR_SWEEP: begin
                if (clr_row == LAST_ROW) begin
                    state_nxt   = CLR_IDLE;
                    clr_row_nxt = '0;
                end else begin
                    clr_row_nxt = clr_row + 1'b1;
                end
            end
            default: state_nxt = CLR_IDLE;
        endcase
    end

    assign busy = (state == CLR_SWEEP);

    logic           a_acc, b_acc;
    logic [BSW-1:0] a_bank, b_bank;
    logic [RW-1:0]  a_row, b_row;

    assign a_acc = a_en & ~busy;
    assign b_acc = b_en & ~busy;
    assign a_row = a_addr[AW-1:BW];
    assign b_row = b_addr[AW-1:BW];

    if (BW > 0) begin : g_bsel
        assign a_bank = a_addr[BSW-1:0];
        assign b_bank = b_addr[BSW-1:0];
    end else begin : g_bsel_single
        assign a_bank = '0;
        assign b_bank = '0;
    end

    logic signed [DW-1:0] a_rdata [NBANK];
    logic signed [DW-1:0] b_rdata [NBANK];

    // The sweep borrows port A of every bank; port B is idle while busy.
    for (genvar i = 0; i < NBANK; i++) begin : g_bank
        logic a_hit, b_hit;
        assign a_hit = a_acc && (a_bank == BSW'(i));
        assign b_hit = b_acc && (b_bank == BSW'(i));

        bram_tdp_bank #(
            .DW      (DW),
            .WORDS   (ROWS),
            .WR_MODE (WR_MODE),
            .RW      (RW)
        ) u_bank (
            .clk    (clk),
            .a_en   (busy | a_hit),
            .a_we   (busy | (a_hit & a_we)),
            .a_addr (busy ? clr_row : a_row),
            .a_din  (busy ? '0 : a_din),
            .a_dout (a_rdata[i]),
            .b_en   (b_hit),
            .b_we   (b_we),
            .b_addr (b_row),
            .b_din  (b_din),
            .b_dout (b_rdata[i])
        );
    end

    logic [LAT-1:0]       a_vld, b_vld;
    logic [BSW-1:0]       a_sel, b_sel;
    logic signed [DW-1:0] a_hold, b_hold;
    logic signed [DW-1:0] a_mux, b_mux;

    assign a_mux = a_rdata[a_sel];
    assign b_mux = b_rdata[b_sel];

    // a_hold is both the RD_LAT=2 output stage and the hold-last-value register.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld  <= '0;
            b_vld  <= '0;
            a_sel  <= '0;
            b_sel  <= '0;
            a_hold <= '0;
            b_hold <= '0;
            coll   <= 1'b0;
        end else begin
            a_vld <= LAT'({a_vld, a_acc});
            b_vld <= LAT'({b_vld, b_acc});
            if (a_acc) begin
                a_sel <= a_bank;
            end
            if (b_acc) begin
                b_sel <= b_bank;
            end
            if (a_vld[0]) begin
                a_hold <= a_mux;
            end
            if (b_vld[0]) begin
                b_hold <= b_mux;
            end
            coll <= a_acc & b_acc & (a_addr == b_addr) & (a_we | b_we);
        end
    end

    assign a_dvalid = a_vld[LAT-1];
    assign b_dvalid = b_vld[LAT-1];
    assign a_dout   = (LAT == 2) ? a_hold : (a_vld[0] ? a_mux : a_hold);
    assign b_dout   = (LAT == 2) ? b_hold : (b_vld[0] ? b_mux : b_hold);

endmodule

// File: tb/tb_bram_tdp_banked.sv
// tb/tb_bram_tdp_banked.sv - self-checking bench for bram_tdp_banked
module tb_bram_tdp_banked;

    localparam int DW    = 16;
    localparam int DEPTH = 1024;
    localparam int NBANK = 4;
    localparam int AW    = 10;
    localparam int ROWS  = DEPTH / NBANK;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1, clr_req = 1'b0;
    logic                 a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
    logic [AW-1:0]        a_addr = '0, b_addr = '0;
    logic signed [DW-1:0] a_din = '0, b_din = '0;

    logic                 busy0, busy1, coll0, coll1;
    logic                 a_dvalid0, a_dvalid1, b_dvalid0, b_dvalid1;
    logic signed [DW-1:0] a_dout0, a_dout1, b_dout0, b_dout1;

    bram_tdp_banked #(
        .DW(DW), .DEPTH(DEPTH), .NBANK(NBANK), .RD_LAT(1), .WR_MODE(0), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout0), .a_dvalid(a_dvalid0),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout0), .b_dvalid(b_dvalid0),
        .coll(coll0)
    );

    bram_tdp_banked #(
        .DW(DW), .DEPTH(DEPTH), .NBANK(NBANK), .RD_LAT(2), .WR_MODE(1), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
        .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout1), .a_dvalid(a_dvalid1),
        .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout1), .b_dvalid(b_dvalid1),
        .coll(coll1)
    );

    // Reference: flat word array, sweep as "rows left", per-instance read pipes.
    // Index k: 0 = RD_LAT 1 / read-first, 1 = RD_LAT 2 / write-first; p: 0 = A, 1 = B.
    logic [DW-1:0] mem [DEPTH];
    int            busy_left = 0;
    bit            pvld [2][2][2];
    logic [DW-1:0] pdat [2][2][2];
    logic [DW-1:0] hold [2][2];
    bit            exp_coll = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [DW-1:0] rd [2][2];
        bit            acc [2];
        bit            new_coll;
        new_coll = 1'b0;
        if (rst) begin
            busy_left = ROWS;
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++) begin
                    pvld[k][p][0] = 1'b0;
                    pvld[k][p][1] = 1'b0;
                    hold[k][p]    = '0;
                end
        end else begin
            acc[0] = a_en && (busy_left == 0);
            acc[1] = b_en && (busy_left == 0);
            for (int k = 0; k < 2; k++) begin
                rd[k][0] = (k == 1 && a_we) ? a_din : mem[a_addr];
                rd[k][1] = (k == 1 && b_we) ? b_din : mem[b_addr];
            end
            new_coll = acc[0] && acc[1] && (a_addr == b_addr) && (a_we || b_we);
            if (busy_left > 0) begin
                for (int j = 0; j < NBANK; j++) mem[(ROWS - busy_left) * NBANK + j] = '0;
                busy_left--;
            end else begin
                if (acc[1] && b_we) mem[b_addr] = b_din;
                if (acc[0] && a_we) mem[a_addr] = a_din;
                if (clr_req) busy_left = ROWS;
            end
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++) begin
                    pvld[k][p][1] = pvld[k][p][0];
                    pdat[k][p][1] = pdat[k][p][0];
                    pvld[k][p][0] = acc[p];
                    pdat[k][p][0] = rd[k][p];
                    if (pvld[k][p][k]) hold[k][p] = pdat[k][p][k];
                end
        end
        exp_coll = new_coll;
        @(posedge clk);
        #1;
        chk("dut0.busy", busy0, busy_left > 0);
        chk("dut1.busy", busy1, busy_left > 0);
        chk("dut0.coll", coll0, exp_coll);
        chk("dut1.coll", coll1, exp_coll);
        chk("dut0.a_dvalid", a_dvalid0, pvld[0][0][0]);
        chk("dut0.b_dvalid", b_dvalid0, pvld[0][1][0]);
        chk("dut1.a_dvalid", a_dvalid1, pvld[1][0][1]);
        chk("dut1.b_dvalid", b_dvalid1, pvld[1][1][1]);
        chk("dut0.a_dout", a_dout0, hold[0][0]);
        chk("dut0.b_dout", b_dout0, hold[0][1]);
        chk("dut1.a_dout", a_dout1, hold[1][0]);
        chk("dut1.b_dout", b_dout1, hold[1][1]);
    endtask

    task automatic drive_a(input bit en, input bit we, input int addr, input int din);
        a_en = en; a_we = we; a_addr = AW'(addr); a_din = DW'(din);
    endtask

    task automatic drive_b(input bit en, input bit we, input int addr, input int din);
        b_en = en; b_we = we; b_addr = AW'(addr); b_din = DW'(din);
    endtask

    task automatic idle_ports();
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy0 === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk(tag, DW'(n), DW'(ROWS));
    endtask

    function automatic int rnd_addr();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 15));
    endfunction

    initial begin
        rst = 1'b1;
        idle_ports();
        repeat (3) tick();
        chk("rst.a_dout0", a_dout0, '0);
        chk("rst.b_dvalid1", b_dvalid1, '0);
        chk("rst.coll0", coll0, '0);
        chk("rst.busy0", busy0, 1'b1);
        rst = 1'b0;
        wait_idle("sweep_len.after_reset");

        drive_a(1, 0, 0, 0); drive_b(1, 0, 513, 0); tick();
        drive_a(1, 0, 1023, 0); drive_b(0, 0, 0, 0); tick();
        chk("rd1023.dvalid0", a_dvalid0, 1'b1);
        chk("rd1023.dout0", a_dout0, '0);
        idle_ports(); tick(); tick();

        drive_a(1, 1, 5, 'h1234); drive_b(1, 0, 5, 0); tick();
        chk("wr_rd5.coll", coll0, 1'b1);
        chk("wr_rd5.b_old", b_dout0, '0);
        drive_a(0, 0, 0, 0); drive_b(1, 0, 5, 0); tick();
        chk("wr_rd5.coll_one_cycle", coll0, 1'b0);
        chk("wr_rd5.b_new", b_dout0, 16'h1234);
        idle_ports(); tick(); tick();

        drive_a(1, 1, 9, 'h00AA); drive_b(1, 1, 9, 'h00BB); tick();
        chk("ww9.coll", coll1, 1'b1);
        drive_a(1, 0, 9, 0); drive_b(0, 0, 0, 0); tick();
        chk("ww9.a_wins", a_dout0, 16'h00AA);
        idle_ports(); tick(); tick();

        drive_a(1, 1, 3, 4); tick();
        drive_a(1, 1, 3, -7); tick();
        chk("rmode.read_first_old", a_dout0, 16'd4);
        idle_ports(); tick();
        chk("rmode.write_first_new", a_dout1, 16'hFFF9);
        tick();

        for (int i = 0; i < 8; i++) begin
            drive_a(1, 0, i, 0);
            drive_b(1, 1, 100 + i, int'($urandom_range(0, 65535)));
            tick();
            chk("stream.no_coll", coll1, 1'b0);
        end
        idle_ports(); repeat (3) tick();

        for (int c = 0; c < 600; c++) begin
            drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd_addr(), int'($urandom_range(0, 65535)));
            drive_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd_addr(), int'($urandom_range(0, 65535)));
            clr_req = ($urandom_range(0, 299) == 0);
            tick();
        end
        clr_req = 1'b0;
        idle_ports();
        repeat (ROWS + 4) tick();

        drive_a(1, 0, 9, 0); tick();
        idle_ports(); rst = 1'b1; tick();
        chk("rst_midread.dvalid1", a_dvalid1, 1'b0);
        rst = 1'b0;
        wait_idle("sweep_len.after_midread_rst");

        for (int i = 0; i < 32; i++) begin
            drive_a(1, 1, i, int'($urandom_range(1, 65535)));
            drive_b(1, 1, 512 + i, int'($urandom_range(1, 65535)));
            tick();
        end
        drive_a(1, 0, 7, 0); drive_b(0, 0, 0, 0); clr_req = 1'b1; tick();
        clr_req = 1'b0;
        drive_a(1, 1, 20, 'h7FFF);
        for (int i = 1; i < 100; i++) begin
            clr_req = (i == 50);
            tick();
            chk("sweep.dropped_no_dvalid", a_dvalid0, 1'b0);
        end
        clr_req = 1'b0;
        idle_ports(); rst = 1'b1; tick();
        rst = 1'b0;
        wait_idle("sweep_len.restart");

        drive_a(1, 0, 20, 0); drive_b(1, 0, 512, 0); tick();
        chk("clear.addr20", a_dout0, '0);
        chk("clear.addr512", b_dout0, '0);
        for (int i = 0; i < 48; i++) begin
            drive_a(1, 0, i, 0);
            drive_b(1, 0, 512 + i, 0);
            tick();
        end
        idle_ports(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
